palette_lookup_arbiter: RTL and testbench
=========================================

// Module: palette_lookup_arbiter
// PURPOSE
//  Shares one combinational 16-entry sprite palette (4-bit index -> 4/4/4 RGB) among NUM_REQ
//  pixel requesters (snake, food, background, score overlay). Round-robin arbitration,
//  2-stage pipeline (index stage, colour stage), valid/ready backpressure on output.
//  Sits between the sprite ROM readers and the VGA colour mapper.
// PARAMETERS
//  NUM_REQ  4  number of requesters (2..8)
//  IDX_W    4  palette index width; palette depth = 2**IDX_W
//  ID_W     2  requester tag width; must satisfy 2**ID_W >= NUM_REQ
// PORTS
//  Clk          in   1            system clock, all logic on rising edge
//  Reset        in   1            synchronous, active-high
//  req          in   NUM_REQ      per-requester request; held until granted
//  req_index    in   NUM_REQ*IDX_W  packed indices, requester i at [i*IDX_W +: IDX_W]
//  grant        out  NUM_REQ      one-hot accept strobe, combinational; req[i]&grant[i] = accepted
//  pal_index    out  IDX_W        index driven to shared palette (stage-1 register)
//  pal_red      in   4            palette red for pal_index, same cycle
//  pal_green    in   4            palette green
//  pal_blue     in   4            palette blue
//  out_valid    out  1            output colour valid
//  out_ready    in   1            downstream accepts colour when out_valid&out_ready
//  out_id       out  ID_W         requester tag of current output
//  out_red      out  4            registered colour
//  out_green    out  4
//  out_blue     out  4
//  out_transparent out 1          see CONFIGURATION
// BEHAVIOUR
//  - Reset (sync, high): s1_valid=0, out_valid=0, out_id=0, out_red/green/blue=0,
//    out_transparent=0, pal_index=0, rr_ptr=0. Reset mid-transfer drops all in-flight data.
//  - advance = !out_valid | out_ready;  s1_free = !s1_valid | advance.
//  - grant: when s1_free and |req, one-hot to first asserted req at or after rr_ptr (wrap
//    modulo NUM_REQ); else all 0. grant never asserts for a req bit that is 0.
//  - Accept edge: s1_valid<=1, s1_id<=granted i, pal_index<=req_index[i]; rr_ptr<=(i+1)%NUM_REQ.
//    No accept and advance: s1_valid<=0. Not s1_free: stage 1 holds, rr_ptr holds.
//  - Colour stage: on edge with advance, out_valid<=s1_valid; if s1_valid, capture
//    pal_red/green/blue and s1_id. Stall (out_valid & !out_ready): all outputs hold stable.
//  - Latency: accept edge N -> out_valid=1 after edge N+1. Throughput 1 pixel/cycle with
//    out_ready held high; simultaneous drain and accept in the same cycle is required.
//  - Fairness: a continuously requesting requester waits at most NUM_REQ-1 grants.
//  - Single requester repeatedly: granted every free cycle (pointer wraps past it and back).
//  - pal_index changes only on accept edges; palette read is combinational, no extra wait.
// CONFIGURATION
//  Macro PALARB_TRANSPARENT_EN:
//   defined: colour stage also registers out_transparent = (s1 index == 0); when set,
//            out_red/green/blue are forced to 0 regardless of palette entry 0.
//   undefined: out_transparent tied 0; index 0 passes palette colour like any other index.
// TESTING
//  1 Reset held 3 cycles with req=4'b1111 -> grant=0 during reset, all outputs 0, out_valid=0.
//  2 req=4'b0001, idx0=5, palette[5]=B/9/7, out_ready=1 -> grant=0001 at accept edge N,
//    pal_index=5 after N, out_valid=1 out_id=0 out_rgb=B/9/7 after N+1.
//  3 req=4'b1111 held, out_ready=1 -> grant order 0,1,2,3,0,... one per cycle; out_id same
//    sequence 2 cycles later, no bubbles.
//  4 Two items in flight, out_ready=0 for 4 cycles -> out_* stable, grant=0, pal_index held;
//    out_ready=1 -> both drain in order, no loss or duplication.
//  5 rr_ptr=2, req=4'b0011 -> grant=0001 (wrap), then next grant 0010.
//  6 idx=0, palette[0]=7/5/0: PALARB_TRANSPARENT_EN defined -> out_transparent=1, rgb=0/0/0;
//    undefined -> out_transparent=0, rgb=7/5/0.

Source files
------------

// File: rtl/palette_lookup_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : palette_lookup_arbiter
//  Description : Round-robin arbiter that shares one combinational 16-entry
//                sprite palette among NUM_REQ pixel requesters. It has two
//                pipeline stages (index, colour) and valid/ready
//                backpressure on the colour output.
//                Optional feature macro: PALARB_TRANSPARENT_EN. When it is
//                defined, palette index 0 is flagged transparent and its
//                colour is forced to black.
//  Revision    : 1.0 - initial release
// ============================================================================
module palette_lookup_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 4,
   parameter int ID_W    = 2
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*IDX_W-1:0] req_index,
   output logic [NUM_REQ-1:0]       grant,
   output logic [IDX_W-1:0]         pal_index,
   input  logic [3:0]               pal_red,
   input  logic [3:0]               pal_green,
   input  logic [3:0]               pal_blue,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ID_W-1:0]          out_id,
   output logic [3:0]               out_red,
   output logic [3:0]               out_green,
   output logic [3:0]               out_blue,
   output logic                     out_transparent
);

   localparam logic [ID_W-1:0] c_LAST_ID = ID_W'(NUM_REQ - 1);

   // Stage 1 (index stage) state
   logic              r_s1_valid;
   logic [ID_W-1:0]   r_s1_id;
   logic [IDX_W-1:0]  r_pal_index;
   logic [ID_W-1:0]   r_rr_ptr;

   // Stage 2 (colour stage) state
   logic              r_out_valid;
   logic [ID_W-1:0]   r_out_id;
   logic [3:0]        r_out_red;
   logic [3:0]        r_out_green;
   logic [3:0]        r_out_blue;
   logic              r_out_transparent;

   // Pipeline control and arbitration results
   logic              w_advance;
   logic              w_s1_free;
   logic              w_found;
   logic [NUM_REQ-1:0] w_grant;
   logic [ID_W-1:0]   w_gnt_id;
   logic [IDX_W-1:0]  w_sel_idx;
   logic [ID_W-1:0]   w_next_ptr;
   logic              w_transp;

   // The colour stage moves whenever it is empty or being drained; stage 1
   // can take a new pixel whenever it is empty or moving forward.
   assign w_advance = !r_out_valid || out_ready;
   assign w_s1_free = !r_s1_valid || w_advance;

   // Round-robin pick: first asserted request at or above the pointer, then
   // wrap around to the ones below it. Held off entirely during reset.
   always_comb begin
      w_grant   = '0;
      w_found   = 1'b0;
      w_gnt_id  = '0;
      w_sel_idx = '0;
      if (!Reset && w_s1_free) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req[i] && (i >= int'(r_rr_ptr))) begin
               w_found    = 1'b1;
               w_grant[i] = 1'b1;
               w_gnt_id   = ID_W'(i);
               w_sel_idx  = req_index[i*IDX_W +: IDX_W];
            end
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req[i] && (i < int'(r_rr_ptr))) begin
               w_found    = 1'b1;
               w_grant[i] = 1'b1;
               w_gnt_id   = ID_W'(i);
               w_sel_idx  = req_index[i*IDX_W +: IDX_W];
            end
         end
      end
   end

   // The pointer moves to the requester just after the winner, modulo NUM_REQ.
   assign w_next_ptr = (w_gnt_id == c_LAST_ID) ? '0 : w_gnt_id + ID_W'(1);

`ifdef PALARB_TRANSPARENT_EN
   assign w_transp = (r_pal_index == '0);
`else
   assign w_transp = 1'b0;
`endif

   // Index stage: latch the winner's index and tag, and rotate the pointer.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_s1_valid  <= 1'b0;
         r_s1_id     <= '0;
         r_pal_index <= '0;
         r_rr_ptr    <= '0;
      end else if (w_found) begin
         r_s1_valid  <= 1'b1;
         r_s1_id     <= w_gnt_id;
         r_pal_index <= w_sel_idx;
         r_rr_ptr    <= w_next_ptr;
      end else if (w_advance) begin
         r_s1_valid  <= 1'b0;
      end
   end

   // Colour stage: capture the combinational palette response when moving.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_out_valid       <= 1'b0;
         r_out_id          <= '0;
         r_out_red         <= '0;
         r_out_green       <= '0;
         r_out_blue        <= '0;
         r_out_transparent <= 1'b0;
      end else if (w_advance) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out_id          <= r_s1_id;
            r_out_red         <= w_transp ? 4'd0 : pal_red;
            r_out_green       <= w_transp ? 4'd0 : pal_green;
            r_out_blue        <= w_transp ? 4'd0 : pal_blue;
            r_out_transparent <= w_transp;
         end
      end
   end

   assign grant           = w_grant;
   assign pal_index       = r_pal_index;
   assign out_valid       = r_out_valid;
   assign out_id          = r_out_id;
   assign out_red         = r_out_red;
   assign out_green       = r_out_green;
   assign out_blue        = r_out_blue;
   assign out_transparent = r_out_transparent;

endmodule
`default_nettype wire

// File: tb/tb_palette_lookup_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_palette_lookup_arbiter
//  Description : Self-checking bench for palette_lookup_arbiter. It has a
//                behavioural pipeline model, an ordering scoreboard, a
//                fairness monitor, directed cases and a randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_palette_lookup_arbiter;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [4*N-1:0] req_idx;
   logic [N-1:0]   grant;
   logic [3:0]     pal_index;
   logic [3:0]     pal_r, pal_g, pal_b;
   logic           out_valid;
   logic           out_ready;
   logic [1:0]     out_id;
   logic [3:0]     out_r, out_g, out_b;
   logic           out_tr;

   logic [11:0]    pal_mem [16];

   assign {pal_r, pal_g, pal_b} = pal_mem[pal_index];

   always #5 clk = ~clk;

   palette_lookup_arbiter #(.NUM_REQ(N), .IDX_W(4), .ID_W(2)) u_dut (
      .Clk(clk), .Reset(rst), .req(req), .req_index(req_idx), .grant(grant),
      .pal_index(pal_index), .pal_red(pal_r), .pal_green(pal_g), .pal_blue(pal_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
      .out_red(out_r), .out_green(out_g), .out_blue(out_b),
      .out_transparent(out_tr)
   );

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   // Expected colour/transparency for a palette index
   function automatic logic [11:0] exp_col(input int idx);
`ifdef PALARB_TRANSPARENT_EN
      if (idx == 0) return 12'h000;
`endif
      return pal_mem[idx];
   endfunction

   function automatic bit exp_tr(input int idx);
`ifdef PALARB_TRANSPARENT_EN
      return (idx == 0);
`else
      return 1'b0;
`endif
   endfunction

   // Behavioural model: one pixel slot in the index stage, one at the output
   typedef struct { int id; logic [11:0] col; bit tr; } item_t;
   item_t       sb[$];
   bit          m_live = 0;
   bit          m_s1_v, m_out_v, m_out_tr;
   int          m_s1_id, m_s1_idx, m_pal, m_out_id, m_ptr;
   logic [11:0] m_out_col;
   logic [N-1:0] e_grant = '0;
   int          wait_cnt [N];

   // Compare DUT against the model every cycle, then step the model
   always @(negedge clk) begin
      bit    adv, free;
      int    gid;
      item_t it;
      adv  = !m_out_v || out_ready;
      free = !m_s1_v || adv;
      gid  = -1;
      if (!rst && m_live && free)
         for (int k = 0; k < N; k++)
            if (gid < 0 && req[(m_ptr + k) % N]) gid = (m_ptr + k) % N;
      e_grant = '0;
      if (gid >= 0) e_grant[gid] = 1'b1;

      chk("grant", 32'(grant), 32'(e_grant));
      if (m_live) begin
         chk("pal_index", 32'(pal_index), 32'(m_pal));
         chk("out_valid", 32'(out_valid), 32'(m_out_v));
         chk("out_id",    32'(out_id),    32'(m_out_id));
         chk("out_rgb",   32'({out_r, out_g, out_b}), 32'(m_out_col));
         chk("out_tr",    32'(out_tr),    32'(m_out_tr));
      end

      if (rst) begin
         m_live = 1; m_s1_v = 0; m_out_v = 0; m_out_tr = 0;
         m_s1_id = 0; m_s1_idx = 0; m_pal = 0; m_out_id = 0; m_ptr = 0;
         m_out_col = 12'h000;
         sb.delete();
         for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      end else if (m_live) begin
         if (m_out_v && out_ready) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               it = sb.pop_front();
               chk("sb_id",  32'(out_id), 32'(it.id));
               chk("sb_rgb", 32'({out_r, out_g, out_b}), 32'(it.col));
               chk("sb_tr",  32'(out_tr), 32'(it.tr));
            end
         end
         for (int i = 0; i < N; i++) begin
            if (gid == i) begin
               chk("fairness", 32'(wait_cnt[i] <= N - 1), 32'd1);
               wait_cnt[i] = 0;
            end else if (!req[i]) wait_cnt[i] = 0;
            else if (gid >= 0) wait_cnt[i]++;
         end
         if (adv) begin
            m_out_v = m_s1_v;
            if (m_s1_v) begin
               m_out_id  = m_s1_id;
               m_out_col = exp_col(m_s1_idx);
               m_out_tr  = exp_tr(m_s1_idx);
            end
         end
         if (gid >= 0) begin
            m_s1_v   = 1;
            m_s1_id  = gid;
            m_s1_idx = int'(req_idx[gid*4 +: 4]);
            m_pal    = m_s1_idx;
            m_ptr    = (gid + 1) % N;
            it.id = gid; it.col = exp_col(m_s1_idx); it.tr = exp_tr(m_s1_idx);
            sb.push_back(it);
         end else if (adv) begin
            m_s1_v = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      int rq_pct, rdy_pct;
      for (int i = 0; i < 16; i++) pal_mem[i] = 12'($urandom);
      pal_mem[5] = 12'hB97;
      pal_mem[0] = 12'h750;

      // Reset with all requests up
      rst = 1'b1; req = 4'b1111; req_idx = 16'h0000; out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("rst_grant",     32'(grant), 32'd0);
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_pal_index", 32'(pal_index), 32'd0);
         chk("rst_out",       32'({out_id, out_r, out_g, out_b, out_tr}), 32'd0);
      end

      // Single pixel: latency and colour
      step(); rst = 1'b0; req = 4'b0001; req_idx = 16'h0005;
      @(negedge clk); chk("t2_grant", 32'(grant), 32'h1);
      step(); req = 4'b0000;
      @(negedge clk);
      chk("t2_pal_index", 32'(pal_index), 32'h5);
      chk("t2_not_yet",   32'(out_valid), 32'h0);
      step();
      @(negedge clk);
      chk("t2_valid", 32'(out_valid), 32'h1);
      chk("t2_id",    32'(out_id), 32'h0);
      chk("t2_rgb",   32'({out_r, out_g, out_b}), 32'hB97);

      // Pointer to 2, then wrap-around priority
      step(); req = 4'b0010; req_idx = 16'h0030;
      @(negedge clk); chk("t5_setup", 32'(grant), 32'h2);
      step(); req = 4'b0011; req_idx = 16'h00A1;
      @(negedge clk); chk("t5_wrap", 32'(grant), 32'h1);
      step(); req = 4'b0010;
      @(negedge clk); chk("t5_next", 32'(grant), 32'h2);

      // All requesting: rotating grants, back-to-back output
      step(); req = 4'b1111; req_idx = 16'h3C81;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("t3_grant", 32'(grant), 32'(1 << ((2 + k) % 4)));
         if (k >= 2) begin
            chk("t3_valid", 32'(out_valid), 32'h1);
            chk("t3_id",    32'(out_id), 32'(k % 4));
         end
         step();
      end

      // Stall with both stages full
      out_ready = 1'b0;
      repeat (4) begin
         @(negedge clk); chk("t4_stall_grant", 32'(grant), 32'h0);
         step();
      end
      out_ready = 1'b1; req = 4'b0000;
      repeat (4) step();

      // Palette index 0
      req = 4'b0001; req_idx = 16'h0000;
      @(negedge clk); chk("t6_grant", 32'(grant), 32'h1);
      step(); req = 4'b0000;
      step();
      @(negedge clk);
      chk("t6_valid", 32'(out_valid), 32'h1);
`ifdef PALARB_TRANSPARENT_EN
      chk("t6_tr",  32'(out_tr), 32'h1);
      chk("t6_rgb", 32'({out_r, out_g, out_b}), 32'h000);
`else
      chk("t6_tr",  32'(out_tr), 32'h0);
      chk("t6_rgb", 32'({out_r, out_g, out_b}), 32'h750);
`endif

      // Randomized phases with varied load, backpressure and rare resets
      for (int ph = 0; ph < 4; ph++) begin
         rq_pct  = (ph == 0) ? 90 : (ph == 1) ? 30 : (ph == 2) ? 70 : 100;
         rdy_pct = (ph == 0) ? 100 : (ph == 1) ? 50 : (ph == 2) ? 20 : 80;
         for (int c = 0; c < 700; c++) begin
            step();
            for (int i = 0; i < N; i++)
               if (req[i] && e_grant[i]) req[i] = 1'b0;
            for (int i = 0; i < N; i++)
               if (!req[i] && ($urandom_range(99, 0) < rq_pct)) begin
                  req[i] = 1'b1;
                  req_idx[i*4 +: 4] = 4'($urandom_range(15, 0));
               end
            out_ready = ($urandom_range(99, 0) < rdy_pct);
            rst = ($urandom_range(499, 0) == 0);
         end
      end

      // Drain
      step(); rst = 1'b0; req = '0; out_ready = 1'b1;
      repeat (6) step();
      @(negedge clk);
      chk("final_sb_empty", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
`default_nettype wire
